// File: rtl/mem_exc_pipe_if.sv
// E-stage request / M-stage exception bundle for mem_exc_pipe.
// The master drives E-stage values and acks; the slave returns the registered exception state.
interface mem_exc_pipe_if #(
  parameter int unsigned CNT_W = 8
);
  logic [31:0]      Instr_E;
  logic [31:0]      ALUout_E;
  logic             overflow_E;
  logic [31:0]      PC_E;
  logic [4:0]       ExcCode_in;
  logic             stall;
  logic             flush;
  logic             cap_clr;
  logic [4:0]       ExcCode_M;
  logic [31:0]      BadVAddr_M;
  logic             cap_valid;
  logic [4:0]       cap_code;
  logic [31:0]      cap_addr;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output Instr_E, ALUout_E, overflow_E, PC_E, ExcCode_in, stall, flush, cap_clr,
    input  ExcCode_M, BadVAddr_M, cap_valid, cap_code, cap_addr, exc_count
  );

  modport slave (
    input  Instr_E, ALUout_E, overflow_E, PC_E, ExcCode_in, stall, flush, cap_clr,
    output ExcCode_M, BadVAddr_M, cap_valid, cap_code, cap_addr, exc_count
  );
endinterface

// File: rtl/mem_exc_pipe.sv
// E-stage exception detection (Ov/AdEL/AdES), E/M exception register,
// first-exception capture and saturating exception counter.
module mem_exc_pipe #(
  parameter logic [31:0] DM_SIZE   = 32'h0000_3000,
  parameter int unsigned TC_NUM    = 2,
  parameter logic [31:0] TC_BASE   = 32'h0000_7F00,
  parameter logic [31:0] TC_STRIDE = 32'h10,
  parameter int unsigned TC_SIZE   = 12,
  parameter int unsigned TC_RO_OFF = 8,
  parameter int unsigned CNT_W     = 8
) (
  input logic         clk,
  input logic         reset_n,
  mem_exc_pipe_if.slave bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic [5:0]  op, fn;
  logic [31:0] addr;
  logic        is_arith, is_load, is_store, is_word, is_half;
  logic        in_dm, in_tc, tc_ro, addr_bad;
  logic [31:0] tc_base, tc_off;
  logic [4:0]  e_code, code_d;
  logic [31:0] bad_d;
  logic        unused_instr;

  logic [4:0]       code_q;
  logic [31:0]      bad_q;
  logic             cap_valid_q;
  logic [4:0]       cap_code_q;
  logic [31:0]      cap_addr_q;
  logic [CNT_W-1:0] cnt_q;

  assign op           = bus.Instr_E[31:26];
  assign fn           = bus.Instr_E[5:0];
  assign addr         = bus.ALUout_E;
  assign unused_instr = ^bus.Instr_E[25:6];

  always_comb begin
    is_arith = ((op == 6'd0) && ((fn == 6'd32) || (fn == 6'd34))) || (op == 6'd8);
    is_load  = (op == 6'd32) || (op == 6'd33) || (op == 6'd35) || (op == 6'd36) || (op == 6'd37);
    is_store = (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
    is_word  = (op == 6'd35) || (op == 6'd43);
    is_half  = (op == 6'd33) || (op == 6'd37) || (op == 6'd41);
    in_dm    = addr < DM_SIZE;

    // base <= addr and (addr - base) < size keeps every window compare free of 32-bit wrap
    in_tc   = 1'b0;
    tc_ro   = 1'b0;
    tc_base = '0;
    tc_off  = '0;
    for (int unsigned k = 0; k < TC_NUM; k++) begin
      tc_base = TC_BASE + k * TC_STRIDE;
      tc_off  = addr - tc_base;
      if ((addr >= tc_base) && (tc_off < TC_SIZE)) begin
        in_tc = 1'b1;
        if ((tc_off >= TC_RO_OFF) && (tc_off < TC_RO_OFF + 32'd4)) tc_ro = 1'b1;
      end
    end

    addr_bad = (is_word && (addr[1:0] != 2'b00)) ||
               (is_half && addr[0]) ||
               (in_tc && !is_word) ||
               bus.overflow_E ||
               !(in_dm || in_tc);

    e_code = EXC_NONE;
    if (is_arith && bus.overflow_E)      e_code = EXC_OV;
    else if (is_load && addr_bad)        e_code = EXC_ADEL;
    else if (is_store && (addr_bad || tc_ro)) e_code = EXC_ADES;

    code_d = (bus.ExcCode_in != EXC_NONE) ? bus.ExcCode_in : e_code;

    bad_d = '0;
    if ((bus.ExcCode_in == EXC_NONE) && ((e_code == EXC_ADEL) || (e_code == EXC_ADES)))
      bad_d = addr;
    else if (bus.ExcCode_in == EXC_ADEL)
      bad_d = bus.PC_E;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q      <= '0;
      bad_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_code_q  <= '0;
      cap_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (bus.flush) begin
        code_q <= '0;
        bad_q  <= '0;
      end else if (!bus.stall) begin
        code_q <= code_d;
        bad_q  <= bad_d;
        if ((code_d != EXC_NONE) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end

      // An ack in the same cycle as a pending M-stage exception re-arms and captures it
      if (!cap_valid_q || bus.cap_clr) begin
        if (code_q != EXC_NONE) begin
          cap_valid_q <= 1'b1;
          cap_code_q  <= code_q;
          cap_addr_q  <= bad_q;
        end else if (bus.cap_clr) begin
          cap_valid_q <= 1'b0;
          cap_code_q  <= '0;
          cap_addr_q  <= '0;
        end
      end
    end
  end

  assign bus.ExcCode_M  = code_q;
  assign bus.BadVAddr_M = bad_q;
  assign bus.cap_valid  = cap_valid_q;
  assign bus.cap_code   = cap_code_q;
  assign bus.cap_addr   = cap_addr_q;
  assign bus.exc_count  = cnt_q;

endmodule

// File: tb/tb_mem_exc_pipe.sv
// Self-checking bench for mem_exc_pipe: directed vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_mem_exc_pipe;

  localparam int unsigned CNT_W = 2;
  localparam longint DM_SIZE = 64'h3000;
  localparam longint TC_BASE = 64'h7F00;
  localparam longint TC_STRIDE = 64'h10;
  localparam longint TC_SIZE = 12;
  localparam longint TC_RO = 8;
  localparam int TC_NUM = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_exc_pipe_if #(.CNT_W(CNT_W)) bus ();

  mem_exc_pipe #(
    .DM_SIZE(32'h0000_3000), .TC_NUM(2), .TC_BASE(32'h0000_7F00),
    .TC_STRIDE(32'h10), .TC_SIZE(12), .TC_RO_OFF(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail = 0;

  // reference state
  int unsigned m_code, m_bad, m_cv, m_cc, m_ca, m_cnt;

  function automatic logic [31:0] mk(input int op, input int fn);
    logic [31:0] r;
    r = '0;
    r[31:26] = op[5:0];
    r[5:0] = fn[5:0];
    return r;
  endfunction

  function automatic int unsigned ref_code(input logic [31:0] ins, input logic [31:0] a32,
                                           input logic ov, input logic [4:0] ein);
    int op, fn, size;
    longint a, lo;
    bit arith, ld, st, in_dm, in_tc, ro, bad;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    arith = (op == 0 && (fn == 32 || fn == 34)) || op == 8;
    ld = op inside {32, 33, 35, 36, 37};
    st = op inside {40, 41, 43};
    size = (op == 35 || op == 43) ? 4 : (op == 33 || op == 37 || op == 41) ? 2 : 1;
    a = longint'(a32);
    in_dm = a < DM_SIZE;
    in_tc = 0;
    ro = 0;
    for (int k = 0; k < TC_NUM; k++) begin
      lo = TC_BASE + k * TC_STRIDE;
      if (a >= lo && a <= lo + TC_SIZE - 1) in_tc = 1;
      if (a >= lo + TC_RO && a <= lo + TC_RO + 3) ro = 1;
    end
    bad = (a % size != 0) || (in_tc && size != 4) || ov || !(in_dm || in_tc);
    if (ein != 0) return ein;
    if (arith) return ov ? 12 : 0;
    if (ld) return bad ? 4 : 0;
    if (st) return (bad || ro) ? 5 : 0;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ExcCode_M"}, 32'(bus.ExcCode_M), m_code);
    chk({tag, ".BadVAddr_M"}, bus.BadVAddr_M, m_bad);
    chk({tag, ".cap_valid"}, 32'(bus.cap_valid), m_cv);
    chk({tag, ".cap_code"}, 32'(bus.cap_code), m_cc);
    chk({tag, ".cap_addr"}, bus.cap_addr, m_ca);
    chk({tag, ".exc_count"}, 32'(bus.exc_count), m_cnt);
  endtask

  task automatic model_reset();
    m_code = 0; m_bad = 0; m_cv = 0; m_cc = 0; m_ca = 0; m_cnt = 0;
  endtask

  // drive at posedge+1, advance one edge, update model, compare at posedge+1
  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic ov,
                      input logic [31:0] pc, input logic [4:0] ein,
                      input logic st, input logic fl, input logic clr, input string tag);
    int unsigned nc, nb;
    bus.Instr_E = ins; bus.ALUout_E = a; bus.overflow_E = ov; bus.PC_E = pc;
    bus.ExcCode_in = ein; bus.stall = st; bus.flush = fl; bus.cap_clr = clr;
    nc = ref_code(ins, a, ov, ein);
    nb = (ein == 0 && (nc == 4 || nc == 5)) ? a : (ein == 4) ? pc : 0;
    @(posedge clk);
    if (!m_cv || clr) begin
      if (m_code != 0) begin m_cv = 1; m_cc = m_code; m_ca = m_bad; end
      else if (clr) begin m_cv = 0; m_cc = 0; m_ca = 0; end
    end
    if (fl) begin m_code = 0; m_bad = 0; end
    else if (!st) begin
      m_code = nc; m_bad = nb;
      if (nc != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic nop(input logic clr, input string tag);
    step('0, '0, 1'b0, '0, 5'd0, 1'b0, 1'b0, clr, tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    #3;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] pc;
    logic [4:0]  ein;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vt[$];

  initial begin
    localparam int LB = 32, LH = 33, LW = 35, LBU = 36, LHU = 37, SB = 40, SH = 41, SW = 43;
    logic [31:0] ins_pool [0:13];
    logic [31:0] ra, ri;

    bus.Instr_E = '0; bus.ALUout_E = '0; bus.overflow_E = 1'b0; bus.PC_E = '0;
    bus.ExcCode_in = '0; bus.stall = 1'b0; bus.flush = 1'b0; bus.cap_clr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    vt.push_back('{mk(LW, 0), 32'h102, 0, 0, 0, 4, 32'h102});
    vt.push_back('{mk(LW, 0), 32'h100, 0, 0, 0, 0, 0});
    vt.push_back('{mk(LH, 0), 32'h101, 0, 0, 0, 4, 32'h101});
    vt.push_back('{mk(LHU, 0), 32'h2FFE, 0, 0, 0, 0, 0});
    vt.push_back('{mk(LW, 0), 32'h2FFC, 0, 0, 0, 0, 0});
    vt.push_back('{mk(LBU, 0), 32'h3000, 0, 0, 0, 4, 32'h3000});
    vt.push_back('{mk(LB, 0), 32'h7F0B, 0, 0, 0, 4, 32'h7F0B});
    vt.push_back('{mk(LW, 0), 32'h7F08, 0, 0, 0, 0, 0});
    vt.push_back('{mk(SW, 0), 32'h7F18, 0, 0, 0, 5, 32'h7F18});
    vt.push_back('{mk(SW, 0), 32'h7F14, 0, 0, 0, 0, 0});
    vt.push_back('{mk(SB, 0), 32'h7F04, 0, 0, 0, 5, 32'h7F04});
    vt.push_back('{mk(SW, 0), 32'h7F1C, 0, 0, 0, 5, 32'h7F1C});
    vt.push_back('{mk(LW, 0), 32'h7F20, 0, 0, 0, 4, 32'h7F20});
    vt.push_back('{mk(SH, 0), 32'h2FFE, 0, 0, 0, 0, 0});
    vt.push_back('{mk(SW, 0), 32'hFFFF_FFFC, 0, 0, 0, 5, 32'hFFFF_FFFC});
    vt.push_back('{mk(0, 32), 32'h1234, 1, 0, 0, 12, 0});
    vt.push_back('{mk(0, 34), 32'h1234, 0, 0, 0, 0, 0});
    vt.push_back('{mk(8, 0), 32'h7, 1, 0, 0, 12, 0});
    vt.push_back('{mk(0, 33), 32'h7, 1, 0, 0, 0, 0});
    vt.push_back('{mk(0, 32), 32'h5, 1, 32'h3001, 4, 4, 32'h3001});
    vt.push_back('{mk(LW, 0), 32'h103, 0, 32'h44, 10, 10, 0});
    vt.push_back('{mk(LW, 0), 32'h100, 1, 0, 0, 4, 32'h100});
    vt.push_back('{mk(2, 0), 32'h103, 1, 0, 0, 0, 0});

    foreach (vt[i]) begin
      step(vt[i].ins, vt[i].addr, vt[i].ov, vt[i].pc, vt[i].ein, 0, 0, 0, "vec");
      chk($sformatf("vec%0d.code", i), 32'(bus.ExcCode_M), 32'(vt[i].exp_code));
      chk($sformatf("vec%0d.bad", i), bus.BadVAddr_M, vt[i].exp_bad);
    end

    // stall + flush together, then stall alone
    do_reset();
    step(mk(SW, 0), 32'h3, 0, 0, 0, 1, 1, 0, "stflush");
    chk("stflush.code", 32'(bus.ExcCode_M), 0);
    chk("stflush.cnt", 32'(bus.exc_count), 0);
    step(mk(LW, 0), 32'h102, 0, 0, 0, 0, 0, 0, "lw102");
    chk("lw102.code", 32'(bus.ExcCode_M), 4);
    chk("lw102.bad", bus.BadVAddr_M, 32'h102);
    step(mk(0, 32), 32'h0, 1, 0, 0, 1, 0, 0, "stall");
    chk("stall.code", 32'(bus.ExcCode_M), 4);
    chk("stall.cap_code", 32'(bus.cap_code), 4);
    chk("stall.cnt", 32'(bus.exc_count), 1);

    // saturating count, capture hold and clear-then-capture
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(mk(LH, 0), 32'h1, 0, 0, 0, 0, 0, 0, "lh");
      chk($sformatf("lh%0d.cnt", i), 32'(bus.exc_count), (i < 3) ? i + 1 : 3);
    end
    chk("lh.cap_code", 32'(bus.cap_code), 4);
    step(mk(SB, 0), 32'h3000, 0, 0, 0, 0, 0, 0, "sb");
    nop(1'b0, "hold");
    chk("hold.cap_code", 32'(bus.cap_code), 4);
    step(mk(SB, 0), 32'h3000, 0, 0, 0, 0, 0, 0, "sb2");
    nop(1'b1, "clrcap");
    chk("clrcap.valid", 32'(bus.cap_valid), 1);
    chk("clrcap.code", 32'(bus.cap_code), 5);
    nop(1'b1, "clr");
    chk("clr.valid", 32'(bus.cap_valid), 0);

    // async reset while captured and saturated
    step(mk(LW, 0), 32'h102, 0, 0, 0, 0, 0, 0, "lw");
    nop(1'b0, "cap");
    chk("cap.valid", 32'(bus.cap_valid), 1);
    chk("cap.addr", bus.cap_addr, 32'h102);
    chk("cap.cnt", 32'(bus.exc_count), 3);
    do_reset();

    // randomized traffic
    ins_pool = '{mk(0, 32), mk(0, 34), mk(8, 0), mk(0, 33), mk(LB, 0), mk(LH, 0), mk(LW, 0),
                 mk(LBU, 0), mk(LHU, 0), mk(SB, 0), mk(SH, 0), mk(SW, 0), mk(4, 0), mk(15, 0)};
    for (int i = 0; i < 600; i++) begin
      ri = ins_pool[$urandom_range(0, 13)];
      case ($urandom_range(0, 4))
        0: ra = $urandom_range(0, 32'h2FFF);
        1: ra = 32'h2FF8 + $urandom_range(0, 16);
        2: ra = 32'h7EF8 + $urandom_range(0, 56);
        3: ra = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: ra = $urandom;
      endcase
      if (i == 300) do_reset();
      step(ri, ra, ($urandom_range(0, 5) == 0), $urandom,
           ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_exc_pipe.md
MEM_EXC_PIPE -- requirements
Module: mem_exc_pipe

Interface
REQ-001 SHALL have parameter DM_SIZE, default 32'h0000_3000, data-memory size in bytes; DM window is [0, DM_SIZE-1].
REQ-002 SHALL have parameter TC_NUM, default 2, number of timer channels (1..4).
REQ-003 SHALL have parameter TC_BASE, default 32'h0000_7F00, base address of timer channel 0.
REQ-004 SHALL have parameter TC_STRIDE, default 32'h10, address distance between timer channels.
REQ-005 SHALL have parameter TC_SIZE, default 12, bytes per timer window.
REQ-006 SHALL have parameter TC_RO_OFF, default 8, byte offset of the read-only count word within each timer window.
REQ-007 SHALL have parameter CNT_W, default 8, width of the exception counter.
REQ-008 clk  input  1  system clock; all state changes on posedge.
REQ-009 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-010 Instr_E  input  32  E-stage instruction.
REQ-011 ALUout_E  input  32  E-stage ALU result / effective address.
REQ-012 overflow_E  input  1  signed overflow of E-stage ALU operation.
REQ-013 PC_E  input  32  E-stage PC.
REQ-014 ExcCode_in  input  5  exception code carried from earlier stages (0 = none).
REQ-015 stall  input  1  hold E/M register.
REQ-016 flush  input  1  clear E/M register.
REQ-017 cap_clr  input  1  release captured exception (handler ack).
REQ-018 ExcCode_M  output  5  registered exception code, M stage.
REQ-019 BadVAddr_M  output  32  registered faulting address, M stage.
REQ-020 cap_valid / cap_code / cap_addr  output  1/5/32  first-exception capture.
REQ-021 exc_count  output  CNT_W  saturating count of exceptions entering M.

Function
REQ-022 Decode SHALL be: ADD (op 0, func 32), SUB (op 0, func 34), ADDI (op 8); loads LB 32, LH 33, LW 35, LBU 36, LHU 37; stores SB 40, SH 41, SW 43.
REQ-023 Timer window k (k<TC_NUM) SHALL be [TC_BASE+k*TC_STRIDE, TC_BASE+k*TC_STRIDE+TC_SIZE-1]; its RO word is bytes TC_RO_OFF..TC_RO_OFF+3 of the window.
REQ-024 ADD/SUB/ADDI with overflow_E=1 SHALL yield code 12 (Ov), else 0.
REQ-025 Load SHALL yield code 4 (AdEL) on any of: LW addr[1:0]!=0; LH/LHU addr[0]!=0; non-word load inside any timer window; overflow_E=1; address outside DM and all timer windows.
REQ-026 Store SHALL yield code 5 (AdES) on the load conditions (store variants) plus any store into a timer RO word.
REQ-027 All other opcodes SHALL yield 0 from E-stage detection.
REQ-028 Nonzero ExcCode_in SHALL take priority over E-stage detection.
REQ-029 Next BadVAddr SHALL be ALUout_E when E-stage yields 4/5 and ExcCode_in=0; PC_E when ExcCode_in=4; else 0.
REQ-030 E/M register SHALL update each posedge: flush -> ExcCode_M=0, BadVAddr_M=0; else stall -> hold; else load next values; flush SHALL beat stall.
REQ-031 Latency SHALL be exactly one cycle from E inputs to ExcCode_M/BadVAddr_M.
REQ-032 Capture: when ExcCode_M!=0 and cap_valid=0, next cycle cap_valid=1, cap_code=ExcCode_M, cap_addr=BadVAddr_M; while cap_valid=1 later exceptions SHALL NOT overwrite.
REQ-033 cap_clr SHALL clear cap_valid next cycle; cap_clr with a new nonzero ExcCode_M same cycle SHALL capture the new exception (clear then capture).
REQ-034 exc_count SHALL increment by 1 on each posedge where a nonzero code is loaded into ExcCode_M (not on stall hold, not on flush), saturating at 2^CNT_W-1.
REQ-035 Address comparisons SHALL be 32-bit unsigned; no wrap across 32'hFFFF_FFFF.

Reset
REQ-036 reset_n=0 SHALL immediately force ExcCode_M=0, BadVAddr_M=0, cap_valid=0, cap_code=0, cap_addr=0, exc_count=0, including mid-stall or mid-capture.
REQ-037 First posedge after reset_n rises SHALL behave as normal operation.

Verification
REQ-038 LW, ALUout_E=32'h0000_0102 -> next cycle ExcCode_M=4, BadVAddr_M=32'h0000_0102, then cap_valid=1, cap_code=4.
REQ-039 SW to 32'h0000_7F18 (TC_NUM=2) -> ExcCode_M=5; SW to 32'h0000_7F14 -> ExcCode_M=0; SB to 32'h0000_7F04 -> 5.
REQ-040 ADD with overflow_E=1 and ExcCode_in=4, PC_E=32'h0000_3001 -> ExcCode_M=4, BadVAddr_M=32'h0000_3001.
REQ-041 Exception with stall=1 and flush=1 same cycle -> ExcCode_M=0, exc_count unchanged; stall alone -> prior value held, count unchanged.
REQ-042 CNT_W=2, five consecutive LH at 32'h0000_0001 -> exc_count sequence 1,2,3,3,3; cap_code stays 4 until cap_clr.
REQ-043 reset_n low mid-sequence with cap_valid=1, exc_count=3 -> all outputs 0 asynchronously before next edge.
